// File: rtl/calc_cmd_driver.sv
// Drives a single-command calculator from a host command FIFO. Each command
// gets one apply pulse, and one sampled response is held until the host takes it.
module calc_cmd_driver #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_LAT   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   input  logic [2:0] cmd_op,
   output logic [7:0] calc_in,
   output logic [2:0] calc_op,
   output logic       calc_apply,
   input  logic [7:0] calc_tail,
   input  logic       calc_empty,
   input  logic       calc_valid,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_empty,
   output logic       rsp_err,
   output logic       busy,
   output logic [7:0] done_cnt
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [7:0]        calc_in_q, calc_in_d;
   logic [2:0]        calc_op_q, calc_op_d;
   logic              calc_apply_q, calc_apply_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_data_q, rsp_data_d;
   logic              rsp_empty_q, rsp_empty_d;
   logic              rsp_err_q, rsp_err_d;
   logic [7:0]        done_cnt_q, done_cnt_d;
   logic [10:0]       mem_q [CMD_DEPTH];

   logic              full, fifo_empty, push, pop, issue_now;
   logic [10:0]       head;

   assign full       = (count_q == CNT_W'(CMD_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = cmd_valid && !full;
   assign pop        = (state_q == ISSUE);
   // With the FIFO empty the command being pushed this cycle is the head, so
   // an idle driver can apply it on the very next cycle.
   assign head       = fifo_empty ? {cmd_op, cmd_data} : mem_q[rd_ptr_q];

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      calc_in_d    = 8'd0;
      calc_op_d    = 3'd0;
      calc_apply_d = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_empty_d  = rsp_empty_q;
      rsp_err_d    = rsp_err_q;
      done_cnt_d   = done_cnt_q;
      issue_now    = 1'b0;

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (!fifo_empty || push) issue_now = 1'b1;
         end
         ISSUE: begin
            state_d = WAIT;
            lat_d   = LAT_W'(RSP_LAT - 1);
         end
         WAIT: begin
            if (lat_q == '0) begin
               rsp_data_d  = calc_tail;
               rsp_empty_d = calc_empty;
               rsp_err_d   = !calc_valid;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + 8'd1;
               if (!fifo_empty) issue_now = 1'b1;
               else             state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue_now) begin
         state_d                = ISSUE;
         calc_apply_d           = 1'b1;
         {calc_op_d, calc_in_d} = head;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         lat_q        <= '0;
         calc_in_q    <= 8'd0;
         calc_op_q    <= 3'd0;
         calc_apply_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 8'd0;
         rsp_empty_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         done_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         lat_q        <= lat_d;
         calc_in_q    <= calc_in_d;
         calc_op_q    <= calc_op_d;
         calc_apply_q <= calc_apply_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_empty_q  <= rsp_empty_d;
         rsp_err_q    <= rsp_err_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
   end

   assign cmd_ready  = !full;
   assign calc_in    = calc_in_q;
   assign calc_op    = calc_op_q;
   assign calc_apply = calc_apply_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_empty  = rsp_empty_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign done_cnt   = done_cnt_q;

endmodule

// File: doc/calc_cmd_driver.md
CALC_CMD_DRIVER -- requirements
Module: calc_cmd_driver

Interface
REQ-001 Parameter CMD_DEPTH, default 4, command FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter RSP_LAT, default 2, cycles from calculator apply to result sampling; at least 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  host offers a command.
REQ-006 cmd_ready  output  1  driver accepts a command this cycle.
REQ-007 cmd_data  input  8  operand value for the calculator `in` port.
REQ-008 cmd_op  input  3  calculator opcode.
REQ-009 calc_in  output  8  drives calculator `in`.
REQ-010 calc_op  output  3  drives calculator `op`.
REQ-011 calc_apply  output  1  drives calculator `apply`, one-cycle pulse.
REQ-012 calc_tail  input  8  calculator `tail`.
REQ-013 calc_empty  input  1  calculator `empty`.
REQ-014 calc_valid  input  1  calculator `valid`; 0 marks an error.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  host consumes the response.
REQ-017 rsp_data  output  8  sampled calc_tail.
REQ-018 rsp_empty  output  1  sampled calc_empty.
REQ-019 rsp_err  output  1  inverse of sampled calc_valid.
REQ-020 busy  output  1  high in every state except IDLE, or while the FIFO is non-empty.
REQ-021 done_cnt  output  8  count of responses consumed by the host.

Function
REQ-022 Command FIFO, CMD_DEPTH entries, each 11 bits {op, data}.
  - cmd_ready = not full.
  - A push occurs when cmd_valid and cmd_ready are both high.
  - No bypass when full: cmd_ready stays 0 in a full cycle even if a pop occurs that cycle.
  - Pointers wrap modulo CMD_DEPTH.
REQ-023 FSM state IDLE: stay while the FIFO is empty; go to ISSUE when it is non-empty.
REQ-024 FSM state ISSUE (one cycle):
  - calc_apply = 1; calc_in and calc_op = FIFO head.
  - Pop the FIFO; go to WAIT.
REQ-025 FSM state WAIT:
  - Load a down-counter with RSP_LAT-1.
  - At count 0, register calc_tail, calc_empty and !calc_valid into the rsp_* registers; go to RESP.
REQ-026 FSM state RESP:
  - rsp_valid = 1; rsp_data, rsp_empty and rsp_err are held stable.
  - When rsp_ready = 1: increment done_cnt; go to ISSUE if the FIFO is non-empty, else IDLE.
REQ-027 Latency, with the apply cycle as cycle A:
  - Sampling occurs on the edge ending cycle A+RSP_LAT.
  - rsp_valid rises in cycle A+RSP_LAT+1.
  - A command pushed in cycle t with the FSM in IDLE and the FIFO empty gives A = t+1.
REQ-028 At most one command is outstanding.
  - calc_apply never asserts in WAIT or RESP.
  - calc_apply is never high in two consecutive cycles.
REQ-029 Outside ISSUE, calc_in = 0, calc_op = 0 and calc_apply = 0, all registered.
REQ-030 A push and a pop in the same cycle (FIFO neither full nor empty) leave the occupancy unchanged and preserve order.
REQ-031 done_cnt wraps from 255 to 0.
REQ-032 rsp_err = 1 does not stall or flush later commands; they issue normally.

Reset
REQ-033 While rst is high, asynchronously, all of the following hold:
  - FSM is in IDLE and the FIFO is emptied.
  - cmd_ready = 1.
  - calc_apply, calc_in, calc_op, rsp_valid, rsp_data, rsp_empty, rsp_err, busy and done_cnt are all 0.
REQ-034 Reset asserted in any state, including mid-ISSUE, mid-WAIT or mid-RESP:
  - The pending command is discarded.
  - No further calc_apply occurs until a new command is pushed after rst falls.
REQ-035 First push is possible in the first cycle after rst deasserts.

Verification
REQ-036 Single command {op=3'd0, data=8'h2A}, RSP_LAT=2, calc_tail=8'h2A, calc_valid=1, rsp_ready=1:
  - calc_apply high for exactly one cycle, the cycle after the push.
  - rsp_valid high 3 cycles after the apply cycle.
  - rsp_data=8'h2A, rsp_err=0, done_cnt=1.
REQ-037 Push 5 commands back-to-back with CMD_DEPTH=4 and rsp_ready=0:
  - cmd_ready drops to 0 once 4 commands are held.
  - With rsp_ready later held 1, all 5 commands issue in order with calc_apply pulses at least RSP_LAT+2 cycles apart.
REQ-038 calc_valid=0 at the sample edge -> rsp_err=1 held until rsp_ready; the next queued command still issues.
REQ-039 rst pulsed during WAIT -> all outputs 0 immediately; no response is produced for the aborted command; done_cnt=0.
REQ-040 256 completed commands -> done_cnt returns to 0.
